// File: rtl/alu_arbiter_if.sv
// Bundles both request channels, the response channel and the grant counters.
// Latency: none (wiring only).
// Backpressure: carries req*_ready toward requesters and rsp_ready toward the shared ALU.
interface alu_arbiter_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    logic          req0_valid;
    logic          req0_ready;
    logic [2:0]    req0_op;
    logic [W-1:0]  req0_a;
    logic [W-1:0]  req0_b;

    logic          req1_valid;
    logic          req1_ready;
    logic [2:0]    req1_op;
    logic [W-1:0]  req1_a;
    logic [W-1:0]  req1_b;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [W-1:0]  rsp_z;
    logic          rsp_zero;

    logic [CW-1:0] gnt_cnt0;
    logic [CW-1:0] gnt_cnt1;

    // Requester / response-consumer side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_z, rsp_zero,
        output rsp_ready,
        input  gnt_cnt0, gnt_cnt1
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_z, rsp_zero,
        input  rsp_ready,
        output gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 32-bit ALU between two requesters, tagged registered response.
// Latency: result visible 1 cycle after the grant; 1 op/cycle with rsp_ready held high.
// Backpressure: grants only when the result slot is empty or draining this cycle; readies low otherwise.
module alu_arbiter #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          rsp_id_q, rsp_id_d;
    logic [W-1:0]  rsp_z_q, rsp_z_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic [CW-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CW-1:0] gnt_cnt1_q, gnt_cnt1_d;

    logic          slot_free;
    logic          gnt0, gnt1, gnt_any;
    logic [2:0]    sel_op;
    logic [W-1:0]  sel_a, sel_b;
    logic [W-1:0]  alu_sum, alu_diff, alu_z;
    logic          alu_lt;

    // Arbitration: readies forced low in reset; prio=1 favours port 1 on contention
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        slot_free = (state_q == EMPTY) || bus.rsp_ready;
        if (rst_n && slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (prio_q) gnt1 = 1'b1;
                else        gnt0 = 1'b1;
            end else if (bus.req0_valid) begin
                gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign gnt_any        = gnt0 | gnt1;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Operand select and shared ALU; op[2] only matters for the add/sub slot
    always_comb begin
        sel_op   = gnt1 ? bus.req1_op : bus.req0_op;
        sel_a    = gnt1 ? bus.req1_a  : bus.req0_a;
        sel_b    = gnt1 ? bus.req1_b  : bus.req0_b;
        alu_sum  = sel_a + sel_b;
        alu_diff = sel_a - sel_b;
        // Signs differ: a is smaller iff a is negative; otherwise a-b cannot overflow
        alu_lt   = (sel_a[W-1] != sel_b[W-1]) ? sel_a[W-1] : alu_diff[W-1];
        alu_z    = '0;
        case (sel_op[1:0])
            2'b00: alu_z = sel_a & sel_b;
            2'b01: alu_z = sel_a | sel_b;
            2'b10: alu_z = sel_op[2] ? alu_diff : alu_sum;
            2'b11: alu_z = {{(W-1){1'b0}}, alu_lt};
            default: alu_z = '0;
        endcase
    end

    // Next state: load result on grant (also replaces a draining result), else drain or hold
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        rsp_id_d   = rsp_id_q;
        rsp_z_d    = rsp_z_q;
        rsp_zero_d = rsp_zero_q;
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        case (state_q)
            EMPTY: if (gnt_any) state_d = FULL;
            FULL:  if (bus.rsp_ready && !gnt_any) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (gnt_any) begin
            prio_d     = ~gnt1;
            rsp_id_d   = gnt1;
            rsp_z_d    = alu_z;
            rsp_zero_d = (alu_z == '0);
        end
        if (gnt0) gnt_cnt0_d = gnt_cnt0_q + CW'(1);
        if (gnt1) gnt_cnt1_d = gnt_cnt1_q + CW'(1);
    end

    // State and datapath registers; reset discards any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            prio_q     <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_z_q    <= '0;
            rsp_zero_q <= 1'b0;
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            rsp_id_q   <= rsp_id_d;
            rsp_z_q    <= rsp_z_d;
            rsp_zero_q <= rsp_zero_d;
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.gnt_cnt0  = gnt_cnt0_q;
    assign bus.gnt_cnt1  = gnt_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: op table, contention, backpressure, reset, counter wrap.
// Latency: checks results one cycle after each grant.
// Backpressure: drives rsp_ready low for stall sequences.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_arbiter_if #(.W(32), .CW(16)) bus ();

    alu_arbiter #(.W(32), .CW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        zero;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op = 3'b000; bus.req0_a = 32'h0; bus.req0_b = 32'h0;
        bus.req1_op = 3'b000; bus.req1_a = 32'h0; bus.req1_b = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 3'b010, 32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1]  = '{1'b1, 3'b111, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0};
        vecs[2]  = '{1'b1, 3'b110, 32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b1, 3'b000, 32'hFFFFFFFE, 32'd1,        32'd0,        1'b1};
        vecs[4]  = '{1'b1, 3'b001, 32'hFFFFFFFE, 32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{1'b1, 3'b110, 32'd9,        32'd9,        32'd0,        1'b1};
        vecs[6]  = '{1'b1, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[7]  = '{1'b0, 3'b011, 32'd1,        32'hFFFFFFFE, 32'd0,        1'b1};
        vecs[8]  = '{1'b0, 3'b100, 32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0};
        vecs[9]  = '{1'b0, 3'b101, 32'h000000F0, 32'h0000003C, 32'h000000FC, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 32'd5,        32'd7,        32'd1,        1'b0};
        vecs[11] = '{1'b0, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0};

        // Reset state, with both requests pending to show readies are held low
        rst_n = 1'b0;
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        #2;
        chk("rst req0_ready", bus.req0_ready, 0);
        chk("rst req1_ready", bus.req1_ready, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_id", bus.rsp_id, 0);
        chk("rst rsp_z", bus.rsp_z, 0);
        chk("rst rsp_zero", bus.rsp_zero, 0);
        chk("rst gnt_cnt0", bus.gnt_cnt0, 0);
        chk("rst gnt_cnt1", bus.gnt_cnt1, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Op table: one request at a time, result checked the cycle after grant
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.rsp_ready = 1'b1;
            if (vecs[i].port) begin
                bus.req1_valid = 1'b1; bus.req1_op = vecs[i].op;
                bus.req1_a = vecs[i].a; bus.req1_b = vecs[i].b;
            end else begin
                bus.req0_valid = 1'b1; bus.req0_op = vecs[i].op;
                bus.req0_a = vecs[i].a; bus.req0_b = vecs[i].b;
            end
            #1;
            chk($sformatf("vec%0d req0_ready", i), bus.req0_ready, !vecs[i].port);
            chk($sformatf("vec%0d req1_ready", i), bus.req1_ready, vecs[i].port);
            @(posedge clk);
            #1;
            idle_inputs();
            chk($sformatf("vec%0d rsp_valid", i), bus.rsp_valid, 1);
            chk($sformatf("vec%0d rsp_id", i), bus.rsp_id, vecs[i].port);
            chk($sformatf("vec%0d rsp_z", i), bus.rsp_z, vecs[i].z);
            chk($sformatf("vec%0d rsp_zero", i), bus.rsp_zero, vecs[i].zero);
        end

        // Contention: both valid for 6 cycles, grants must alternate starting at port 0
        do_reset();
        @(negedge clk);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        bus.req1_valid = 1'b1; bus.req1_op = 3'b010; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("cont%0d req0_ready", i), bus.req0_ready, (i % 2) == 0);
            chk($sformatf("cont%0d req1_ready", i), bus.req1_ready, (i % 2) == 1);
            if (i > 0) chk($sformatf("cont%0d rsp_id", i), bus.rsp_id, (i - 1) % 2);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("cont rsp_valid", bus.rsp_valid, 1);
        chk("cont last rsp_id", bus.rsp_id, 1);
        chk("cont last rsp_z", bus.rsp_z, 4);
        chk("cont gnt_cnt0", bus.gnt_cnt0, 3);
        chk("cont gnt_cnt1", bus.gnt_cnt1, 3);

        // Backpressure: result held for 4 stalled cycles, then drain and grant together
        @(negedge clk);
        chk("bp drained", bus.rsp_valid, 0);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 32'd100; bus.req0_b = 32'd1;
        #1;
        chk("bp first req0_ready", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        bus.req0_a = 32'd200; bus.req0_b = 32'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d req0_ready", i), bus.req0_ready, 0);
            chk($sformatf("bp%0d req1_ready", i), bus.req1_ready, 0);
            chk($sformatf("bp%0d rsp_valid", i), bus.rsp_valid, 1);
            chk($sformatf("bp%0d rsp_z", i), bus.rsp_z, 101);
            chk($sformatf("bp%0d rsp_id", i), bus.rsp_id, 0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp release req0_ready", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("bp next rsp_valid", bus.rsp_valid, 1);
        chk("bp next rsp_z", bus.rsp_z, 202);

        // Reset mid-stream with a pending result and prio pointing at port 1
        do_reset();
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b1; bus.req1_op = 3'b010; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
        chk("mid pre rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst rsp_valid", bus.rsp_valid, 0);
        chk("mid rst rsp_z", bus.rsp_z, 0);
        chk("mid rst rsp_zero", bus.rsp_zero, 0);
        chk("mid rst rsp_id", bus.rsp_id, 0);
        chk("mid rst gnt_cnt0", bus.gnt_cnt0, 0);
        chk("mid rst req0_ready", bus.req0_ready, 0);
        chk("mid rst req1_ready", bus.req1_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("mid post req0_ready", bus.req0_ready, 1);
        chk("mid post req1_ready", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("mid post rsp_id", bus.rsp_id, 0);
        chk("mid post rsp_z", bus.rsp_z, 7);
        chk("mid post gnt_cnt0", bus.gnt_cnt0, 1);

        // Counter wrap: 65,537 back-to-back grants to port 0
        do_reset();
        @(negedge clk);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b000;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap gnt_cnt0 max", bus.gnt_cnt0, 32'h0000FFFF);
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        chk("wrap gnt_cnt0", bus.gnt_cnt0, 1);
        chk("wrap gnt_cnt1", bus.gnt_cnt1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
